// File: rtl/hkspi_pkg.sv
// rtl/hkspi_pkg.sv - shared constants and state encoding for the housekeeping SPI responder
package hkspi_pkg;

   // Width of the per-byte bit counter (8 bits per byte)
   localparam int BIT_CNT_W = 3;

   // Command byte values
   localparam logic [7:0] CMD_NOP    = 8'h00;
   localparam logic [7:0] CMD_WR     = 8'h80;
   localparam logic [7:0] CMD_RD     = 8'h40;
   localparam logic [7:0] CMD_RW     = 8'hC0;
   localparam logic [7:0] CMD_STATUS = 8'h10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_IGNORE
   } hk_state_e;

endpackage

// File: rtl/hkspi_sync.sv
// rtl/hkspi_sync.sv - pad synchronizer and edge pulses for csb/sck, plain sync for sdi
//
// Ports:
//   clock, reset           core clock, async active-high reset
//   spi_csb/spi_sck/spi_sdi raw pad inputs
//   csb_s, sdi_s           synchronized levels
//   csb_rise/csb_fall      one-cycle pulses on synchronized csb edges
//   sck_rise/sck_fall      one-cycle pulses on synchronized sck edges
module hkspi_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic spi_csb,
   input  logic spi_sck,
   input  logic spi_sdi,
   output logic csb_s,
   output logic csb_rise,
   output logic csb_fall,
   output logic sck_rise,
   output logic sck_fall,
   output logic sdi_s
);

   logic [SYNC_STAGES-1:0] csb_pipe;
   logic [SYNC_STAGES-1:0] sck_pipe;
   logic [SYNC_STAGES-1:0] sdi_pipe;
   logic                   csb_prev;
   logic                   sck_prev;

   // Reset to the idle bus levels so no spurious edge appears after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         csb_pipe <= '1;
         sck_pipe <= '0;
         sdi_pipe <= '0;
         csb_prev <= 1'b1;
         sck_prev <= 1'b0;
      end else begin
         csb_pipe <= {csb_pipe[SYNC_STAGES-2:0], spi_csb};
         sck_pipe <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
         sdi_pipe <= {sdi_pipe[SYNC_STAGES-2:0], spi_sdi};
         csb_prev <= csb_pipe[SYNC_STAGES-1];
         sck_prev <= sck_pipe[SYNC_STAGES-1];
      end
   end

   assign csb_s    = csb_pipe[SYNC_STAGES-1];
   assign sdi_s    = sdi_pipe[SYNC_STAGES-1];
   assign csb_rise =  csb_s & ~csb_prev;
   assign csb_fall = ~csb_s &  csb_prev;
   assign sck_rise =  sck_pipe[SYNC_STAGES-1] & ~sck_prev;
   assign sck_fall = ~sck_pipe[SYNC_STAGES-1] &  sck_prev;

endmodule

// File: rtl/housekeeping_spi_responder.sv
// rtl/housekeeping_spi_responder.sv - mode-0 SPI target giving byte-wide register access
//
// Optional feature macro: HKSPI_STATUS_EN (command 0x10 returns a sticky error status byte)
//
// Ports:
//   clock, reset          core clock, async active-high reset
//   spi_csb/sck/sdi       pad inputs, oversampled into clock
//   spi_sdo, spi_sdo_oeb  serial out and active-low pad enable
//   reg_addr, reg_wdata   register bus address / write data
//   reg_we, reg_re        one-cycle write / read strobes
//   reg_rdata             read data, captured the cycle after reg_re
//   busy                  synchronized chip select is active
import hkspi_pkg::*;

module housekeeping_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              spi_csb,
   input  logic              spi_sck,
   input  logic              spi_sdi,
   output logic              spi_sdo,
   output logic              spi_sdo_oeb,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);

   logic csb_s, csb_rise, csb_fall, sck_rise, sck_fall, sdi_s;

   hkspi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock    (clock),
      .reset    (reset),
      .spi_csb  (spi_csb),
      .spi_sck  (spi_sck),
      .spi_sdi  (spi_sdi),
      .csb_s    (csb_s),
      .csb_rise (csb_rise),
      .csb_fall (csb_fall),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .sdi_s    (sdi_s)
   );

   hk_state_e            state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   logic [6:0]           in_shift_q;
   logic [7:0]           out_shift_q;
   logic                 mode_wr_q, mode_rd_q, mode_st_q;
   logic                 re_pend_q;
   logic [7:0]           byte_in;
   logic                 byte_end;
   logic                 cmd_wr, cmd_rd, cmd_st;
`ifdef HKSPI_STATUS_EN
   logic                 cmd_bad;
   logic                 err_q;
`endif

   // Byte as it stands including the bit sampled this cycle
   assign byte_in  = {in_shift_q, sdi_s};
   // SCK events are still honoured in the cycle CSB rises, so a strobe
   // coinciding with deselect is issued before returning to idle
   assign byte_end = sck_rise && (state_q != ST_IDLE) && (&bit_cnt_q);

   always_comb begin
      cmd_wr = 1'b0;
      cmd_rd = 1'b0;
      cmd_st = 1'b0;
`ifdef HKSPI_STATUS_EN
      cmd_bad = 1'b0;
`endif
      case (byte_in)
         CMD_WR:     cmd_wr = 1'b1;
         CMD_RD:     cmd_rd = 1'b1;
         CMD_RW:     begin cmd_wr = 1'b1; cmd_rd = 1'b1; end
         CMD_NOP:    ;
`ifdef HKSPI_STATUS_EN
         CMD_STATUS: cmd_st = 1'b1;
         default:    cmd_bad = 1'b1;
`else
         default:    ;
`endif
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (csb_fall) state_d = ST_CMD;
         ST_CMD: begin
            if (byte_end) begin
               if (cmd_wr || cmd_rd) state_d = ST_ADDR;
               else if (cmd_st)      state_d = ST_DATA;
               else                  state_d = ST_IGNORE;
            end
         end
         ST_ADDR: if (byte_end) state_d = ST_DATA;
         default: ;
      endcase
      if (csb_rise) state_d = ST_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt_q   <= '0;
         in_shift_q  <= '0;
         out_shift_q <= '0;
         mode_wr_q   <= 1'b0;
         mode_rd_q   <= 1'b0;
         mode_st_q   <= 1'b0;
         re_pend_q   <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_we      <= 1'b0;
         reg_re      <= 1'b0;
`ifdef HKSPI_STATUS_EN
         err_q       <= 1'b0;
`endif
      end else begin
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         re_pend_q <= 1'b0;

         if (state_q == ST_IDLE && csb_fall) begin
            bit_cnt_q  <= '0;
            in_shift_q <= '0;
         end else if (sck_rise && state_q != ST_IDLE) begin
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            in_shift_q <= byte_in[6:0];
         end

         // The fall right after a byte boundary (count 0) must not shift:
         // the freshly loaded MSB is already presented on sdo
         if (reg_re)
            out_shift_q <= reg_rdata;
         else if (sck_fall && state_q == ST_DATA && bit_cnt_q != '0)
            out_shift_q <= {out_shift_q[6:0], 1'b0};

         if (byte_end) begin
            case (state_q)
               ST_CMD: begin
                  mode_wr_q <= cmd_wr;
                  mode_rd_q <= cmd_rd;
                  mode_st_q <= cmd_st;
`ifdef HKSPI_STATUS_EN
                  if (cmd_st) begin
                     out_shift_q <= {7'b0, err_q};
                     err_q       <= 1'b0;
                  end else if (cmd_bad) begin
                     err_q <= 1'b1;
                  end
`endif
               end
               ST_ADDR: begin
                  reg_addr <= byte_in[ADDR_W-1:0];
                  reg_re   <= mode_rd_q;
               end
               ST_DATA: begin
                  if (mode_wr_q) begin
                     // Write first; address bump (and prefetch) follow next cycle
                     reg_we    <= 1'b1;
                     reg_wdata <= byte_in;
                     re_pend_q <= 1'b1;
                  end else if (mode_rd_q) begin
                     reg_addr <= reg_addr + 1'b1;
                     reg_re   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end

         if (re_pend_q) begin
            reg_addr <= reg_addr + 1'b1;
            reg_re   <= mode_rd_q && (state_q != ST_IDLE);
         end
      end
   end

   assign spi_sdo     = out_shift_q[7];
   assign spi_sdo_oeb = ~((state_q == ST_DATA) && (mode_rd_q || mode_st_q) && !csb_s);
   assign busy        = ~csb_s;

endmodule

// File: tb/tb_housekeeping_spi_responder.sv
// tb/tb_housekeeping_spi_responder.sv - randomized self-checking bench against a transaction-level model
module tb_housekeeping_spi_responder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       spi_csb = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0;
   logic       spi_sdo, spi_sdo_oeb, reg_we, reg_re, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;

   housekeeping_spi_responder dut (
      .clock(clock), .reset(reset),
      .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
      .spi_sdo(spi_sdo), .spi_sdo_oeb(spi_sdo_oeb),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Register-file stub the DUT talks to
   logic [7:0] stub_mem [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = 8'h00, pre_data = 8'h00;
   assign reg_rdata = stub_mem[reg_addr];
   always @(posedge clock) begin
      if (pre_we)      stub_mem[pre_addr] <= pre_data;
      else if (reg_we) stub_mem[reg_addr] <= reg_wdata;
   end

   // Observed strobe traffic
   logic [15:0] we_q [$];
   logic [7:0]  re_q [$];
   int          both_cnt, oeb_low_cnt;
   always @(negedge clock) begin
      if (!reset) begin
         if (reg_we) we_q.push_back({reg_addr, reg_wdata});
         if (reg_re) re_q.push_back(reg_addr);
         if (reg_we && reg_re) both_cnt++;
         if (!spi_sdo_oeb) oeb_low_cnt++;
      end
   end

   // Reference model state
   logic [7:0] model_mem [256];
   bit         model_err;

   logic [7:0] tx [8];
   logic [7:0] rx [8];
   int         n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Host: mode 0, sck = clock/8, sdo sampled just before each rising edge
   task automatic spi_txn(input int nfull, input int cut_bits, input bit hold_cs);
      int         nb;
      logic [7:0] r;
      we_q.delete(); re_q.delete(); both_cnt = 0; oeb_low_cnt = 0;
      spi_csb = 1'b0;
      repeat (4) @(negedge clock);
      for (int b = 0; b < nfull + ((cut_bits > 0) ? 1 : 0); b++) begin
         nb = (b == nfull) ? cut_bits : 8;
         r  = 8'h00;
         for (int i = 0; i < nb; i++) begin
            spi_sdi = tx[b][7-i];
            repeat (4) @(negedge clock);
            r = {r[6:0], spi_sdo};
            spi_sck = 1'b1;
            repeat (4) @(negedge clock);
            spi_sck = 1'b0;
         end
         rx[b] = r;
      end
      if (!hold_cs) begin
         repeat (4) @(negedge clock);
         spi_csb = 1'b1;
         repeat (10) @(negedge clock);
      end
   endtask

   // One full transaction: cmd, addr, n data bytes from tx[2..], checked against the model
   task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n);
      logic [7:0]  exp_rx [8];
      logic [15:0] exp_we [$];
      logic [7:0]  exp_re [$];
      logic [7:0]  a;
      bit          writes, reads, status, known;
      tx[0] = cmd; tx[1] = addr;
      writes = (cmd == 8'h80) || (cmd == 8'hC0);
      reads  = (cmd == 8'h40) || (cmd == 8'hC0);
      status = 1'b0;
`ifdef HKSPI_STATUS_EN
      status = (cmd == 8'h10);
`endif
      known = writes || reads || status || (cmd == 8'h00);
      if (reads) exp_re.push_back(addr);
      if (reads || writes) begin
         for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            exp_rx[2+i] = model_mem[a];
            if (writes) begin
               exp_we.push_back({a, tx[2+i]});
               model_mem[a] = tx[2+i];
            end
            if (reads) exp_re.push_back(a + 8'd1);
         end
      end
      if (status) begin
         exp_rx[1] = {7'b0, model_err};
         for (int i = 0; i < n; i++) exp_rx[2+i] = 8'h00;
         model_err = 1'b0;
      end
`ifdef HKSPI_STATUS_EN
      if (!known) model_err = 1'b1;
`endif
      spi_txn(2 + n, 0, 1'b0);
      check($sformatf("we_cnt c%0h", cmd), we_q.size(), exp_we.size());
      for (int i = 0; i < exp_we.size() && i < we_q.size(); i++)
         check($sformatf("we%0d c%0h", i, cmd), we_q[i], exp_we[i]);
      check($sformatf("re_cnt c%0h", cmd), re_q.size(), exp_re.size());
      for (int i = 0; i < exp_re.size() && i < re_q.size(); i++)
         check($sformatf("re%0d c%0h", i, cmd), re_q[i], exp_re[i]);
      check("we_re_overlap", both_cnt, 0);
      check($sformatf("oeb_active c%0h", cmd), oeb_low_cnt > 0, reads || status);
      if (status) check("status_byte", rx[1], exp_rx[1]);
      if (reads || status)
         for (int i = 0; i < n; i++)
            check($sformatf("rd%0d c%0h", i, cmd), rx[2+i], exp_rx[2+i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sdo"}, spi_sdo, 1'b0);
      check({tag, "_oeb"}, spi_sdo_oeb, 1'b1);
      check({tag, "_addr"}, reg_addr, 8'h00);
      check({tag, "_wdata"}, reg_wdata, 8'h00);
      check({tag, "_we"}, reg_we, 1'b0);
      check({tag, "_re"}, reg_re, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      logic [7:0] cmd, addr;
      int         n;
      model_err = 1'b0;
      // Preload register file while in reset
      for (int i = 0; i < 256; i++) begin
         pre_we   = 1'b1;
         pre_addr = 8'(i);
         pre_data = (i == 8'h20) ? 8'h3C : (i == 8'h21) ? 8'hC3 : 8'($urandom_range(0, 255));
         model_mem[i] = pre_data;
         @(negedge clock);
      end
      pre_we = 1'b0;
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Write two bytes at 0x10
      tx[2] = 8'hA5; tx[3] = 8'h5A;
      run_txn(8'h80, 8'h10, 2);
      // Read two bytes at 0x20
      run_txn(8'h40, 8'h20, 2);
      check("rd_20", rx[2], 8'h3C);
      check("rd_21", rx[3], 8'hC3);
      // Read+write at the top of the address space
      tx[2] = 8'h11;
      run_txn(8'hC0, 8'hFF, 1);

      // Deselect after 5 bits of a data byte
      tx[0] = 8'h80; tx[1] = 8'h30; tx[2] = 8'hE7;
      spi_txn(2, 5, 1'b1);
      spi_csb = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_oeb", spi_sdo_oeb, 1'b1);
      repeat (10) @(negedge clock);
      check("abort_no_we", we_q.size(), 0);
      tx[2] = 8'h96;
      run_txn(8'h80, 8'h30, 1);

      // Invalid command then status command
      run_txn(8'h7E, 8'h00, 1);
      run_txn(8'h10, 8'h00, 1);
`ifdef HKSPI_STATUS_EN
      check("status_set", rx[1], 8'h01);
`endif
      run_txn(8'h10, 8'h00, 1);

      // Reset in the middle of a read
      tx[0] = 8'h40; tx[1] = 8'h20;
      spi_txn(2, 3, 1'b1);
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      spi_csb = 1'b1; spi_sck = 1'b0;
      model_err = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      run_txn(8'h40, 8'h21, 2);

      // Randomized transactions
      for (int t = 0; t < 20; t++) begin
         case ($urandom_range(0, 5))
            0: cmd = 8'h80;
            1: cmd = 8'h40;
            2: cmd = 8'hC0;
            3: cmd = 8'h10;
            4: cmd = 8'h00;
            default: cmd = 8'($urandom_range(0, 255));
         endcase
         addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) tx[2+i] = 8'($urandom_range(0, 255));
         run_txn(cmd, addr, n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
